// File: rtl/ecg_sample_framer.sv
// ECG sample framer: captures one multi-channel sample vector per tick and streams it channel by channel.
// Optional FRAMER_OVERRUN_CNT_EN adds a saturating 16-bit count of dropped ticks.
module ecg_sample_framer #(
    parameter int CHANNELS   = 8,
    parameter int DATA_W     = 16,
    parameter int WINDOW_LEN = 256,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int WIN_W     = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [CHANNELS*DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0]          out_data,
    output logic [CH_W-1:0]            out_channel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eow,
    output logic [WIN_W-1:0]           frame_idx,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       clear_overrun
`ifdef FRAMER_OVERRUN_CNT_EN
    ,
    output logic [15:0]                overrun_count
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic              tick_q;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [WIN_W-1:0]  frame_idx_q, frame_idx_d;
    logic [DATA_W-1:0] frame_q [CHANNELS];
    logic [DATA_W-1:0] frame_d [CHANNELS];
    logic              overrun_q, overrun_d;
`ifdef FRAMER_OVERRUN_CNT_EN
    logic [15:0]       ovr_cnt_q, ovr_cnt_d;
`endif

    logic tick_rise, accept, last_beat, last_frame, load, drop;

    assign tick_rise  = tick & ~tick_q;
    assign accept     = (state_q == SEND) && out_ready;
    assign last_beat  = (ch_idx_q == CH_W'(CHANNELS - 1));
    assign last_frame = (frame_idx_q == WIN_W'(WINDOW_LEN - 1));
    // A tick coinciding with the final accept chains straight into the next frame.
    assign load       = tick_rise && ((state_q == IDLE) || (accept && last_beat));
    assign drop       = tick_rise && (state_q == SEND) && !(accept && last_beat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_q      <= 1'b0;
            ch_idx_q    <= '0;
            frame_idx_q <= '0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) frame_q[k] <= '0;
`ifdef FRAMER_OVERRUN_CNT_EN
            ovr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick;
            ch_idx_q    <= ch_idx_d;
            frame_idx_q <= frame_idx_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
`ifdef FRAMER_OVERRUN_CNT_EN
            ovr_cnt_q   <= ovr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_rise) state_d = SEND;
            SEND:    if (accept && last_beat && !tick_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d     = frame_q;
        ch_idx_d    = ch_idx_q;
        frame_idx_d = frame_idx_q;
        if (load) begin
            for (int k = 0; k < CHANNELS; k++) frame_d[k] = sample_in[k*DATA_W +: DATA_W];
        end
        if (load) begin
            ch_idx_d = '0;
        end else if (accept) begin
            ch_idx_d = last_beat ? '0 : ch_idx_q + 1'b1;
        end
        if (accept && last_beat) begin
            frame_idx_d = last_frame ? '0 : frame_idx_q + 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)               overrun_d = 1'b1;
        else if (clear_overrun) overrun_d = 1'b0;
        else                    overrun_d = overrun_q;
`ifdef FRAMER_OVERRUN_CNT_EN
        if (drop && clear_overrun)   ovr_cnt_d = 16'd1;
        else if (drop)               ovr_cnt_d = (ovr_cnt_q == 16'hFFFF) ? ovr_cnt_q : ovr_cnt_q + 16'd1;
        else if (clear_overrun)      ovr_cnt_d = '0;
        else                         ovr_cnt_d = ovr_cnt_q;
`endif
    end

    always_comb begin
        out_valid   = (state_q == SEND);
        busy        = (state_q == SEND);
        out_sof     = (state_q == SEND) && (ch_idx_q == '0);
        out_eow     = (state_q == SEND) && last_beat && last_frame;
        out_channel = ch_idx_q;
        frame_idx   = frame_idx_q;
        overrun     = overrun_q;
        out_data    = frame_q[0];
        for (int k = 1; k < CHANNELS; k++) begin
            if (ch_idx_q == CH_W'(k)) out_data = frame_q[k];
        end
`ifdef FRAMER_OVERRUN_CNT_EN
        overrun_count = ovr_cnt_q;
`endif
    end

endmodule

// File: tb/tb_ecg_sample_framer.sv
// Bench for ecg_sample_framer with CHANNELS=4, WINDOW_LEN=4: frame table plus corner-case sequences, beats scoreboarded.
module tb_ecg_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [63:0] sample_in;
    logic [15:0] out_data;
    logic [1:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eow;
    logic [1:0]  frame_idx;
    logic        busy;
    logic        overrun;
    logic        clear_overrun;
`ifdef FRAMER_OVERRUN_CNT_EN
    logic [15:0] overrun_count;
`endif

    ecg_sample_framer #(.CHANNELS(4), .DATA_W(16), .WINDOW_LEN(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .sample_in(sample_in),
        .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eow(out_eow),
        .frame_idx(frame_idx), .busy(busy), .overrun(overrun),
        .clear_overrun(clear_overrun)
`ifdef FRAMER_OVERRUN_CNT_EN
        , .overrun_count(overrun_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] samples;
        logic [1:0]  fidx;
        logic        eow;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
        logic        sof;
        logic        eow;
        logic [1:0]  fidx;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_beats  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic push_frame(input logic [63:0] s, input logic [1:0] f, input logic e);
        for (int c = 0; c < 4; c++) begin
            beat_t b;
            b.data = s[c*16 +: 16];
            b.ch   = 2'(c);
            b.sof  = (c == 0);
            b.eow  = e && (c == 3);
            b.fidx = f;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        check("idle_reached", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted beat is compared against the next expected beat.
    always @(negedge clk) begin
        beat_t b;
        if (rst && out_valid && out_ready) begin
            n_beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat: got data=%h ch=%0d with nothing expected", out_data, out_channel);
            end else begin
                b = exp_q.pop_front();
                if (out_data === b.data && out_channel === b.ch && out_sof === b.sof &&
                    out_eow === b.eow && frame_idx === b.fidx) begin
                    n_pass++;
                    $display("beat data=%h ch=%0d sof=%0b eow=%0b frame=%0d", out_data, out_channel, out_sof, out_eow, frame_idx);
                end else begin
                    $display("FAIL beat: got data=%h ch=%0d sof=%0b eow=%0b frame=%0d, expected data=%h ch=%0d sof=%0b eow=%0b frame=%0d",
                             out_data, out_channel, out_sof, out_eow, frame_idx,
                             b.data, b.ch, b.sof, b.eow, b.fidx);
                end
            end
        end
    end

    vec_t vecs [5];
    int   beats0;

    initial begin
        vecs[0] = '{64'h0004_0003_0002_0001, 2'd0, 1'b0};
        vecs[1] = '{64'hAAAA_5555_FFFF_0000, 2'd1, 1'b0};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 2'd2, 1'b0};
        vecs[3] = '{64'h8000_0001_7FFF_FFFE, 2'd3, 1'b1};
        vecs[4] = '{64'h0BAD_F00D_CAFE_BEEF, 2'd0, 1'b0};

        rst = 1'b0; tick = 1'b0; out_ready = 1'b1; clear_overrun = 1'b0; sample_in = '0;
        #3;
        check("rst_valid",   32'(out_valid),   32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_frame",   32'(frame_idx),   32'd0);
        check("rst_data",    32'(out_data),    32'd0);
        check("rst_channel", 32'(out_channel), 32'd0);
        check("rst_sof_eow", 32'({out_sof, out_eow}), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Basic frame and window wrap from the table.
        for (int v = 0; v < 5; v++) begin
            sample_in = vecs[v].samples;
            push_frame(vecs[v].samples, vecs[v].fidx, vecs[v].eow);
            tick = 1'b1;
            check("valid_before_rise", 32'(out_valid), 32'd0);
            step();
            tick = 1'b0;
            sample_in = {$urandom, $urandom};
            check("latency_valid", 32'(out_valid), 32'd1);
            check("latency_channel", 32'(out_channel), 32'd0);
            wait_idle();
            step(); step();
        end

        // Backpressure on channel 2.
        sample_in = 64'h0004_0003_0002_0001;
        push_frame(sample_in, 2'd1, 1'b0);
        pulse_tick();
        step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid",   32'(out_valid),   32'd1);
            check("bp_channel", 32'(out_channel), 32'd2);
            check("bp_data",    32'(out_data),    32'h0003);
        end
        out_ready = 1'b1;
        wait_idle();
        step();

        // Tick held high produces a single frame.
        sample_in = 64'h4444_3333_2222_1111;
        push_frame(sample_in, 2'd2, 1'b0);
        beats0 = n_beats;
        tick = 1'b1;
        repeat (10) step();
        tick = 1'b0;
        wait_idle();
        check("level_beats", 32'(n_beats - beats0), 32'd4);
        check("level_no_overrun", 32'(overrun), 32'd0);
        step();

        // Overrun: drops while stalled on channel 1, then drop versus clear.
        sample_in = 64'h0D0D_0C0C_0B0B_0A0A;
        push_frame(sample_in, 2'd3, 1'b1);
        beats0 = n_beats;
        pulse_tick();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; sample_in = {$urandom, $urandom};
            step();
            tick = 1'b0;
            step();
        end
        check("ovr_channel_held", 32'(out_channel), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
`ifdef FRAMER_OVERRUN_CNT_EN
        check("ovr_count3", 32'(overrun_count), 32'd3);
`endif
        tick = 1'b1; clear_overrun = 1'b1;
        step();
        tick = 1'b0; clear_overrun = 1'b0;
        check("ovr_drop_beats_clear", 32'(overrun), 32'd1);
`ifdef FRAMER_OVERRUN_CNT_EN
        check("ovr_count_clear_drop", 32'(overrun_count), 32'd1);
`endif
        out_ready = 1'b1;
        wait_idle();
        check("ovr_beats", 32'(n_beats - beats0), 32'd4);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
`ifdef FRAMER_OVERRUN_CNT_EN
        check("ovr_count_cleared", 32'(overrun_count), 32'd0);
`endif
        step();

        // Back-to-back: tick rises on the final-accept cycle.
        sample_in = 64'h0404_0303_0202_0101;
        push_frame(sample_in, 2'd0, 1'b0);
        push_frame(64'h4040_3030_2020_1010, 2'd1, 1'b0);
        pulse_tick();
        step(); step(); step();
        check("b2b_setup_ch3", 32'(out_channel), 32'd3);
        tick = 1'b1;
        sample_in = 64'h4040_3030_2020_1010;
        step();
        tick = 1'b0;
        sample_in = {$urandom, $urandom};
        check("b2b_valid",   32'(out_valid),   32'd1);
        check("b2b_channel", 32'(out_channel), 32'd0);
        check("b2b_data",    32'(out_data),    32'h1010);
        check("b2b_no_ovr",  32'(overrun),     32'd0);
        wait_idle();
        check("b2b_no_ovr_end", 32'(overrun), 32'd0);
        step();

        // Asynchronous reset mid-frame, with overrun set.
        sample_in = 64'h0999_0888_0777_0666;
        push_frame(sample_in, 2'd2, 1'b0);
        pulse_tick();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("ar_setup_ovr",   32'(overrun),     32'd1);
        check("ar_setup_frame", 32'(frame_idx),   32'd2);
        check("ar_setup_ch",    32'(out_channel), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_valid",   32'(out_valid), 32'd0);
        check("ar_busy",    32'(busy),      32'd0);
        check("ar_frame",   32'(frame_idx), 32'd0);
        check("ar_overrun", 32'(overrun),   32'd0);
        exp_q.delete();
        step(); step();
        rst = 1'b1;
        step();
        sample_in = 64'h00F3_00F2_00F1_00F0;
        push_frame(sample_in, 2'd0, 1'b0);
        pulse_tick();
        check("ar_first_ch",    32'(out_channel), 32'd0);
        check("ar_first_frame", 32'(frame_idx),   32'd0);
        wait_idle();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
